// File: rtl/bcd_countdown_timer_if.sv
// Keypad-side inputs and display/control-side outputs of the MM:SS countdown timer.
// The master drives the keypad inputs; the timer is the slave.
interface bcd_countdown_timer_if #(
    parameter int MIN_DIGITS = 2
);
    logic [3:0]              data;
    logic                    loadn;
    logic                    start;
    logic                    pause;
    logic                    cancel;
    logic [3:0]              sec_ones;
    logic [3:0]              sec_tens;
    logic [4*MIN_DIGITS-1:0] mins;
    logic                    zero;
    logic                    running;
    logic                    done;

    modport master (
        output data, loadn, start, pause, cancel,
        input  sec_ones, sec_tens, mins, zero, running, done
    );

    modport slave (
        input  data, loadn, start, pause, cancel,
        output sec_ones, sec_tens, mins, zero, running, done
    );
endinterface

// File: rtl/bcd_countdown_timer.sv
// MM:SS BCD countdown timer with keypad shift-in entry, seconds prescaler,
// start/pause/cancel control, +30 s quick add and a one-cycle completion pulse.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   IDLE    | digits may be keyed in; start launches a valid, non-zero entry
//   RUNNING | prescaler counts; each tick decrements; start adds 30 s
//   PAUSED  | prescaler frozen; digits may be keyed in; start resumes
module bcd_countdown_timer #(
    parameter int MIN_DIGITS    = 2,
    parameter int TICKS_PER_SEC = 100
) (
    input  logic                  clock,
    input  logic                  clearn,
    bcd_countdown_timer_if.slave  bus
);

    localparam int ND = MIN_DIGITS + 2;
    localparam int PW = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0] PRE_TOP = PW'(TICKS_PER_SEC - 1);

    // digit 0 = seconds units, 1 = seconds tens, 2.. = minutes (LSD first)
    typedef logic [ND-1:0][3:0] digits_t;
    typedef enum logic [1:0] {IDLE, RUNNING, PAUSED} state_t;

    state_t        state_q, state_d;
    digits_t       digits_q, digits_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          done_q, done_d;

    logic          tick;
    logic          zero;
    digits_t       dec_val;

    function automatic logic [3:0] digit_max(input int i);
        return (i == 1) ? 4'd5 : 4'd9;
    endfunction

    function automatic digits_t bcd_dec(input digits_t d);
        digits_t r;
        logic    borrow;
        r      = d;
        borrow = 1'b1;
        for (int i = 0; i < ND; i++) begin
            if (borrow) begin
                if (r[i] == 4'd0) begin
                    r[i] = digit_max(i);
                end else begin
                    r[i]   = r[i] - 4'd1;
                    borrow = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // +30 s lands on the seconds-tens digit; overflow past the top minute saturates
    function automatic digits_t bcd_add30(input digits_t d);
        digits_t r;
        logic    carry;
        r     = d;
        carry = 1'b0;
        if (r[1] >= 4'd3) begin
            r[1]  = r[1] - 4'd3;
            carry = 1'b1;
        end else begin
            r[1] = r[1] + 4'd3;
        end
        for (int i = 2; i < ND; i++) begin
            if (carry) begin
                if (r[i] == 4'd9) begin
                    r[i] = 4'd0;
                end else begin
                    r[i]  = r[i] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        if (carry) begin
            for (int i = 0; i < ND; i++) begin
                r[i] = digit_max(i);
            end
        end
        return r;
    endfunction

    assign zero    = (digits_q == '0);
    assign tick    = (pre_q == '0);
    assign dec_val = bcd_dec(digits_q);

    always_ff @(posedge clock or negedge clearn) begin
        if (!clearn) begin
            state_q  <= IDLE;
            digits_q <= '0;
            pre_q    <= PRE_TOP;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            digits_q <= digits_d;
            pre_q    <= pre_d;
            done_q   <= done_d;
        end
    end

    // The highest-priority asserted input owns the cycle, even when it is ignored.
    always_comb begin
        state_d  = state_q;
        digits_d = digits_q;
        pre_d    = pre_q;
        done_d   = 1'b0;

        if (bus.cancel) begin
            state_d  = IDLE;
            digits_d = '0;
            pre_d    = PRE_TOP;
        end else if (bus.pause) begin
            if (state_q == RUNNING) begin
                state_d = PAUSED;
            end
        end else if (bus.start) begin
            if (state_q == RUNNING) begin
                pre_d    = tick ? PRE_TOP : pre_q - PW'(1);
                digits_d = bcd_add30(tick ? dec_val : digits_q);
            end else if (!zero && (digits_q[1] <= 4'd5)) begin
                state_d = RUNNING;
            end
        end else if (state_q == RUNNING) begin
            pre_d = tick ? PRE_TOP : pre_q - PW'(1);
            if (tick) begin
                digits_d = dec_val;
                if (dec_val == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
        end else if (!bus.loadn && (bus.data <= 4'd9)) begin
            digits_d = {digits_q[ND-2:0], bus.data};
        end
    end

    assign bus.sec_ones = digits_q[0];
    assign bus.sec_tens = digits_q[1];
    assign bus.mins     = digits_q[ND-1:2];
    assign bus.zero     = zero;
    assign bus.running  = (state_q == RUNNING);
    assign bus.done     = done_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Bench for bcd_countdown_timer: vector table, hand-written corner sequences and
// random stimulus checked against a total-seconds reference model.
module tb_bcd_countdown_timer;

    localparam int MD     = 2;
    localparam int T      = 4;
    localparam int ND     = MD + 2;
    localparam int MAXSEC = (10**MD - 1) * 60 + 59;
    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_PAUSE = 2;

    logic clock = 1'b0;
    logic clearn;
    always #5 clock = ~clock;

    bcd_countdown_timer_if #(.MIN_DIGITS(MD)) bus ();

    bcd_countdown_timer #(.MIN_DIGITS(MD), .TICKS_PER_SEC(T)) dut (
        .clock  (clock),
        .clearn (clearn),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: digit list plus seconds arithmetic
    int m_dig[ND];
    int m_state;
    int m_cnt;
    bit m_done;

    typedef struct {
        bit         c, p, s, l;
        logic [3:0] d;
        logic [3:0] e_ones, e_tens;
        logic [7:0] e_mins;
        bit         e_run, e_done;
    } vec_t;
    vec_t tbl[14];

    function automatic int to_sec();
        int mn = 0;
        for (int i = MD - 1; i >= 0; i--) mn = mn * 10 + m_dig[2+i];
        return mn * 60 + m_dig[1] * 10 + m_dig[0];
    endfunction

    task automatic from_sec(input int s);
        int mn;
        m_dig[0] = (s % 60) % 10;
        m_dig[1] = (s % 60) / 10;
        mn = s / 60;
        for (int i = 0; i < MD; i++) begin
            m_dig[2+i] = mn % 10;
            mn = mn / 10;
        end
    endtask

    function automatic bit m_zero();
        return to_sec() == 0 && m_dig[1] == 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ND; i++) m_dig[i] = 0;
        m_state = S_IDLE;
        m_cnt   = 0;
        m_done  = 0;
    endtask

    task automatic model_step(input bit c, input bit p, input bit s, input bit l, input int d);
        bit tick;
        int tot;
        m_done = 0;
        tick = (m_cnt == T - 1);
        if (c) begin
            for (int i = 0; i < ND; i++) m_dig[i] = 0;
            m_state = S_IDLE;
            m_cnt   = 0;
        end else if (p) begin
            if (m_state == S_RUN) m_state = S_PAUSE;
        end else if (s) begin
            if (m_state == S_RUN) begin
                m_cnt = tick ? 0 : m_cnt + 1;
                tot = to_sec() - (tick ? 1 : 0) + 30;
                if (tot > MAXSEC) tot = MAXSEC;
                from_sec(tot);
            end else if (!m_zero() && m_dig[1] <= 5) begin
                m_state = S_RUN;
            end
        end else if (m_state == S_RUN) begin
            m_cnt = tick ? 0 : m_cnt + 1;
            if (tick) begin
                tot = to_sec() - 1;
                from_sec(tot);
                if (tot == 0) begin
                    m_state = S_IDLE;
                    m_done  = 1;
                    m_cnt   = 0;
                end
            end
        end else if (!l && d <= 9) begin
            for (int i = ND - 1; i >= 1; i--) m_dig[i] = m_dig[i-1];
            m_dig[0] = d;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        int em = 0;
        for (int i = 0; i < MD; i++) em = em | (m_dig[2+i] << (4 * i));
        check({tag, "_ones"}, int'(bus.sec_ones), m_dig[0]);
        check({tag, "_tens"}, int'(bus.sec_tens), m_dig[1]);
        check({tag, "_mins"}, int'(bus.mins), em);
        check({tag, "_zero"}, int'(bus.zero), int'(m_zero()));
        check({tag, "_run"},  int'(bus.running), int'(m_state == S_RUN));
        check({tag, "_done"}, int'(bus.done), int'(m_done));
    endtask

    task automatic step(input string tag, input bit c, input bit p, input bit s, input bit l, input int d);
        bus.cancel = c;
        bus.pause  = p;
        bus.start  = s;
        bus.loadn  = l;
        bus.data   = 4'(d);
        @(posedge clock);
        model_step(c, p, s, l, d);
        #1;
        check_model(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 0, 0, 0, 1, 0);
    endtask

    task automatic enter(input int d);
        step("key", 0, 0, 0, 0, d);
    endtask

    task automatic go();
        step("start", 0, 0, 1, 1, 0);
    endtask

    task automatic cancel_now();
        step("cancel", 1, 0, 0, 1, 0);
    endtask

    function automatic int shown();
        return int'({bus.mins, bus.sec_tens, bus.sec_ones});
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_done;
        int done_cnt;
        int run_at_done;

        tbl[0]  = '{0, 0, 0, 0, 4'h1, 4'd1, 4'd0, 8'h00, 0, 0};
        tbl[1]  = '{0, 0, 0, 0, 4'h2, 4'd2, 4'd1, 8'h00, 0, 0};
        tbl[2]  = '{0, 0, 0, 0, 4'h3, 4'd3, 4'd2, 8'h01, 0, 0};
        tbl[3]  = '{0, 0, 0, 0, 4'h4, 4'd4, 4'd3, 8'h12, 0, 0};
        tbl[4]  = '{0, 0, 0, 0, 4'hB, 4'd4, 4'd3, 8'h12, 0, 0};
        tbl[5]  = '{0, 0, 0, 1, 4'h6, 4'd4, 4'd3, 8'h12, 0, 0};
        tbl[6]  = '{0, 0, 1, 1, 4'h0, 4'd4, 4'd3, 8'h12, 1, 0};
        tbl[7]  = '{0, 0, 0, 0, 4'h7, 4'd4, 4'd3, 8'h12, 1, 0};
        tbl[8]  = '{1, 0, 0, 1, 4'h0, 4'd0, 4'd0, 8'h00, 0, 0};
        tbl[9]  = '{0, 0, 1, 1, 4'h0, 4'd0, 4'd0, 8'h00, 0, 0};
        tbl[10] = '{0, 0, 0, 0, 4'h7, 4'd7, 4'd0, 8'h00, 0, 0};
        tbl[11] = '{0, 0, 0, 0, 4'h0, 4'd0, 4'd7, 8'h00, 0, 0};
        tbl[12] = '{0, 0, 1, 1, 4'h0, 4'd0, 4'd7, 8'h00, 0, 0};
        tbl[13] = '{1, 0, 0, 1, 4'h0, 4'd0, 4'd0, 8'h00, 0, 0};

        clearn     = 1'b0;
        bus.cancel = 0;
        bus.pause  = 0;
        bus.start  = 0;
        bus.loadn  = 1;
        bus.data   = 0;
        model_reset();
        #12;
        check("rst_ones", int'(bus.sec_ones), 0);
        check("rst_tens", int'(bus.sec_tens), 0);
        check("rst_mins", int'(bus.mins), 0);
        check("rst_zero", int'(bus.zero), 1);
        check("rst_run",  int'(bus.running), 0);
        check("rst_done", int'(bus.done), 0);
        @(negedge clock);
        clearn = 1'b1;

        // entry, invalid digit, reject of 00:00 and of tens=7
        for (int i = 0; i < 14; i++) begin
            step($sformatf("tbl%0d", i), tbl[i].c, tbl[i].p, tbl[i].s, tbl[i].l, int'(tbl[i].d));
            check($sformatf("tbl%0d_vones", i), int'(bus.sec_ones), int'(tbl[i].e_ones));
            check($sformatf("tbl%0d_vtens", i), int'(bus.sec_tens), int'(tbl[i].e_tens));
            check($sformatf("tbl%0d_vmins", i), int'(bus.mins), int'(tbl[i].e_mins));
            check($sformatf("tbl%0d_vrun", i),  int'(bus.running), int'(tbl[i].e_run));
            check($sformatf("tbl%0d_vdone", i), int'(bus.done), int'(tbl[i].e_done));
        end

        // full countdown from 01:00
        enter(1); enter(0); enter(0);
        go();
        first_done  = 0;
        done_cnt    = 0;
        run_at_done = -1;
        for (int k = 1; k <= 300; k++) begin
            idle("cd");
            if (k == 3) check("cd_before_first", shown(), 'h0100);
            if (k == 4) check("cd_first_dec", shown(), 'h0059);
            if (k == 8) check("cd_second_dec", shown(), 'h0058);
            if (bus.done) begin
                done_cnt++;
                if (first_done == 0) begin
                    first_done  = k;
                    run_at_done = int'(bus.running);
                end
            end
        end
        check("cd_done_cycle", first_done, 240);
        check("cd_done_count", done_cnt, 1);
        check("cd_run_at_done", run_at_done, 0);

        // pause / resume keeps the partial second
        enter(1); enter(0);
        go();
        idle("pr"); idle("pr");
        step("pr_pause", 0, 1, 0, 1, 0);
        for (int k = 0; k < 20; k++) idle("pr_hold");
        check("pr_held", shown(), 'h0010);
        check("pr_paused_run", int'(bus.running), 0);
        go();
        idle("pr");
        check("pr_resume1", shown(), 'h0010);
        idle("pr");
        check("pr_resume2", shown(), 'h0009);
        cancel_now();

        // quick add
        enter(4); enter(5);
        go();
        go();
        check("qa_45", shown(), 'h0115);
        cancel_now();
        enter(9); enter(9); enter(4); enter(5);
        go();
        go();
        check("qa_sat", shown(), 'h9959);
        cancel_now();

        // tick and +30 in the same cycle
        enter(1);
        go();
        idle("tq"); idle("tq"); idle("tq");
        go();
        check("tq_value", shown(), 'h0030);
        check("tq_run", int'(bus.running), 1);
        check("tq_done", int'(bus.done), 0);
        cancel_now();

        // cancel mid-run
        enter(5); enter(3); enter(0);
        go();
        idle("cx");
        cancel_now();
        check("cx_value", shown(), 0);
        check("cx_run", int'(bus.running), 0);
        check("cx_done", int'(bus.done), 0);
        idle("cx_after");

        // asynchronous reset mid-count
        enter(2); enter(0);
        go();
        idle("ar"); idle("ar"); idle("ar");
        #3 clearn = 1'b0;
        #1;
        model_reset();
        check("ar_value", shown(), 0);
        check("ar_zero", int'(bus.zero), 1);
        check("ar_run", int'(bus.running), 0);
        check("ar_done", int'(bus.done), 0);
        @(negedge clock);
        clearn = 1'b1;
        idle("ar_after");

        // random traffic against the model
        for (int k = 0; k < 3000; k++) begin
            bit c, p, s, l;
            int d;
            c = ($urandom_range(0, 99) < 2);
            p = ($urandom_range(0, 15) == 0);
            s = ($urandom_range(0, 9) == 0);
            l = ($urandom_range(0, 2) != 0);
            d = int'($urandom_range(0, 15));
            step("rnd", c, p, s, l, d);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_countdown_timer.md
# bcd_countdown_timer

Parametrised MM:SS countdown timer for the microwave controller, the next generation of the basic digit timer. It adds a configurable number of minute digits, an internal seconds prescaler, a start/pause/cancel state machine, a +30 s "quick add" and a one-cycle completion pulse. Keypad digits shift in from the right. It sits between the keypad decoder and the display/magnetron control logic.

## Interface
- MIN_DIGITS, default 2, number of BCD minute digits (legal 1..3).
- TICKS_PER_SEC, default 100, clock cycles per one-second decrement (legal >= 2).

- clock  input  1  rising-edge system clock.
- clearn  input  1  asynchronous, active-low reset.
- data  input  4  BCD keypad digit.
- loadn  input  1  active-low digit-entry strobe, sampled each clock.
- start  input  1  start / resume / +30 s, sampled each clock.
- pause  input  1  pause request.
- cancel  input  1  abort and clear.
- sec_ones  output  4  seconds units digit.
- sec_tens  output  4  seconds tens digit.
- mins  output  4*MIN_DIGITS  minute digits, least significant digit in bits [3:0].
- zero  output  1  high when every digit is 0.
- running  output  1  high in RUNNING.
- done  output  1  one-cycle pulse when a countdown reaches 00:00.

## Operation
- States: IDLE, RUNNING, PAUSED. All digit registers, the prescaler and the state are clocked; zero is combinational from the digit registers.
- Input priority per clock: cancel > pause > start > loadn.
- cancel, in any state:
  - go to IDLE;
  - clear all digits to 0;
  - clear the prescaler to 0.
- loadn low, in IDLE or PAUSED, with data <= 9, shifts the digits:
  - sec_ones <= data;
  - sec_tens <= sec_ones;
  - mins[0] <= sec_tens;
  - mins[k] <= mins[k-1];
  - the top minute digit is discarded.
  - data > 9 causes no shift.
  - loadn is ignored in RUNNING.
  - Shifting is level-sensitive: one shift per clock while loadn is low.
- start:
  - In IDLE or PAUSED, go to RUNNING. It is ignored if zero = 1 or sec_tens > 5 (invalid entry); the state is unchanged.
  - In RUNNING, add 30 s in BCD: seconds carry at 60, minute digits carry at 10. If the result exceeds the maximum (all minute digits 9, 59 s), saturate to the maximum.
- pause:
  - RUNNING goes to PAUSED; the prescaler is frozen.
  - Ignored in IDLE and PAUSED.
- Prescaler:
  - Counts 0..TICKS_PER_SEC-1 only in RUNNING.
  - A tick occurs on the cycle it holds TICKS_PER_SEC-1; it then wraps to 0.
  - It is reset to 0 on entry to IDLE.
- Tick in RUNNING: decrement with borrow.
  - sec_ones 0 -> 9 with borrow.
  - sec_tens 0 -> 5 with borrow.
  - Each minute digit 0 -> 9 with borrow.
  - If the decremented value is 00:00: done = 1 on the next cycle, state goes to IDLE, running = 0.
- Tick and +30 s in the same cycle:
  - Apply the decrement first, then +30. Net effect is +29 s, saturating.
  - done is not asserted. Example: 00:01 becomes 00:30 and stays RUNNING.

## Timing
- Reset (clearn low, asynchronous): all digits 0, zero = 1, running = 0, done = 0, state IDLE, prescaler 0.
- Digit shift visible one cycle after the clock edge that sampled loadn low.
- Minute and seconds updates are visible the cycle after the sampling edge.
- The first decrement after start (from IDLE) occurs exactly TICKS_PER_SEC cycles after the start edge.
- A later decrement follows every TICKS_PER_SEC RUNNING cycles. Paused cycles do not count.
- done:
  - Registered; high for exactly one cycle, coincident with the first cycle the digits read 0.
  - running falls in that same cycle.
- Reset asserted mid-countdown: immediate return to reset values; no done pulse.

## Test plan
Parameters for all scenarios: MIN_DIGITS=2, TICKS_PER_SEC=4.
- Entry: reset, then enter digits 1, 2, 3, 4 one per cycle with loadn low -> mins=0x01? no: mins=0x12, sec_tens=3, sec_ones=4. Then data=0xB with loadn low -> no change.
- Countdown: enter 1,0,0 (01:00), start -> 00:59 after 4 cycles, 00:58 after 8 cycles. Reaches 00:00 after 240 cycles with a single done pulse, running falls.
- Pause/resume: 00:10 running, pause after 2 cycles, hold for 20 cycles with no change, start -> next decrement 2 cycles later.
- Quick add and saturation:
  - start while running at 00:45 -> 01:15.
  - At 99:45 -> 99:59.
  - Same-cycle tick at 00:01 -> 00:30, no done.
- Rejects/cancel:
  - start at 00:00 or with sec_tens=7 -> stays IDLE.
  - cancel while running at 05:30 -> 00:00, IDLE, no done.
  - clearn pulsed mid-count -> all reset values.
